text_ram_arbiter: RTL
=====================

# text_ram_arbiter

Single-cycle-grant arbiter and sequencer for the text-mode character/attribute RAM. Shares one single-port 16-bit RAM (char in [7:0], attr in [15:8]) between three requesters: the text scan-out fetch (hard real-time), the Wishbone CPU port, and a built-in clear-screen engine. Sits between the Wishbone interconnect, the character RAM and the text-mode pixel path, all on the pixel clock domain.

## Interface
Parameters:
- NUM_CELLS, 2400: number of valid cells (80x30).
- CLEAR_CHAR, 8'h20: character written by the clear engine.

Ports:
- I_clk  in  1  clock (pixel clock domain).
- I_rst_n  in  1  reset, asynchronous, active-low.
- I_vid_req  in  1  scan-out fetch request, single-cycle pulse.
- I_vid_addr  in  12  cell address for the fetch.
- O_vid_char  out  8  fetched character.
- O_vid_attr  out  8  fetched attribute.
- O_vid_valid  out  1  fetch data valid, single-cycle pulse.
- I_wb_cyc, I_wb_stb  in  1 each  Wishbone classic cycle/strobe.
- I_wb_we  in  1  write enable.
- I_wb_adr  in  12  cell address.
- I_wb_sel  in  2  byte select: bit0 = char, bit1 = attr.
- I_wb_dat  in  16  write data.
- O_wb_dat  out  16  read data.
- O_wb_ack  out  1  acknowledge, single-cycle pulse.
- I_clr_start  in  1  start clear, single-cycle pulse.
- I_clr_attr  in  8  attribute written by the clear engine.
- O_clr_busy  out  1  clear in progress.
- O_ram_en  out  1  RAM access enable.
- O_ram_we  out  2  RAM byte write enables.
- O_ram_addr  out  12  RAM address.
- O_ram_wdata  out  16  RAM write data.
- I_ram_rdata  in  16  RAM read data; 1-cycle read latency.

## Operation
- Fixed priority per cycle: video > Wishbone > clear. At most one RAM access per cycle.
- RAM control outputs are combinational from the grant. All other outputs are registered.
- Video contract: I_vid_req is never high on two consecutive cycles. Violation is a bench assertion failure, not handled in RTL.
- Video fetch: granted unconditionally.
  - Out-of-range address (>= NUM_CELLS): no RAM access; returns 16'h0000 with normal timing.
- Wishbone FSM:
  - States: IDLE, WAIT_GNT, RD_DATA, ACK.
  - IDLE -> WAIT_GNT on cyc&stb.
  - WAIT_GNT -> on grant: write goes to ACK; read goes to RD_DATA.
  - RD_DATA captures I_ram_rdata into O_wb_dat, then goes to ACK.
  - ACK drives O_wb_ack for one cycle, then returns to IDLE.
  - cyc dropping before grant returns the FSM to IDLE without access or ack.
  - Writes use O_ram_we = I_wb_sel.
  - Out-of-range address: still granted and acked; write dropped (O_ram_en=0); read returns 16'h0000.
- Clear engine:
  - I_clr_start loads counter = 0 and sets busy.
  - Writes {I_clr_attr, CLEAR_CHAR} with we=2'b11 on each cycle where it wins the grant, then increments.
  - Busy clears in the cycle after the write to NUM_CELLS-1.
  - I_clr_start while busy restarts the counter at 0.
  - Wishbone writes during a clear are legal; the clear may later overwrite them.
  - I_clr_attr is sampled at every clear write, not latched at start.
- Reset (asynchronous, any time): O_vid_valid=0, O_vid_char=0, O_vid_attr=0, O_wb_ack=0, O_wb_dat=0, O_clr_busy=0, FSM=IDLE, clear counter=0, no RAM access. An in-flight fetch, Wishbone transaction or clear is abandoned.

## Timing
- Video: request at cycle t -> RAM access at t -> O_vid_valid and data at t+2. Latency is fixed and never stretched.
- Wishbone write: grant at g -> ack at g+1.
- Wishbone read: grant at g -> ack and data at g+2.
- Wishbone first-grant latency after stb: 1 or 2 cycles, since the video contract guarantees a free slot in any 2 consecutive cycles.
- Wishbone back-to-back: a new request is seen only in IDLE, so minimum transaction spacing is 3 cycles for writes and 4 for reads.
- Clear throughput: 1 cell/cycle when uncontended, so a full clear takes >= 2400 cycles.
- Clear starvation bound: a continuous Wishbone stream still leaves a free slot at least every 3rd cycle.

## Structure
- Package text_ram_pkg:
  - NUM_CELLS and CLEAR_CHAR defaults.
  - Grant encoding enum GNT_NONE/GNT_VID/GNT_WB/GNT_CLR.
  - Wishbone FSM state enum.
  - Byte-lane index constants CHAR_LANE=0, ATTR_LANE=1.
- Sub-module text_clear_engine: counter, busy flag, restart logic. Interface: req/addr/wdata out, gnt in.
- Top level: priority mux, Wishbone FSM, video return pipeline.

## Test plan
- Video fetch of cell 81 (preloaded with 16'h1F41) -> O_vid_valid 2 cycles later, char=8'h41, attr=8'h1F. Fetch of cell 2400 -> 16'h0000 with no RAM access.
- Wishbone write to cell 5 with sel=2'b01, dat=16'hAA42, over attr 8'h07 -> RAM reads back 16'h0742. Wishbone read returns it with ack at g+2.
- Video req coinciding with Wishbone stb -> video accesses at t, Wishbone at t+1. Both data paths are correct, with no dropped or stretched fetch.
- I_clr_start with I_clr_attr=8'h1E and no contention -> cells 0..2399 = 16'h1E20, busy low after 2400 write cycles. Restart at cell 1000 -> counter returns to 0.
- Clear running under continuous Wishbone writes plus video every 16 cycles -> clear completes, no Wishbone ack is lost, and every video valid arrives exactly at t+2.
- I_rst_n pulsed mid-read and mid-clear -> all outputs 0 immediately, no ack after release, busy=0.

Source files
------------

// File: rtl/text_ram_pkg.sv
// Shared types and constants for the text-mode character/attribute RAM arbiter.
package text_ram_pkg;

  localparam int         DEF_NUM_CELLS  = 2400;
  localparam logic [7:0] DEF_CLEAR_CHAR = 8'h20;

  localparam int CHAR_LANE = 0;
  localparam int ATTR_LANE = 1;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_VID,
    GNT_WB,
    GNT_CLR
  } gnt_e;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_WAIT_GNT,
    WB_RD_DATA,
    WB_ACK
  } wb_state_e;

  function automatic logic in_range(input logic [11:0] addr, input int num_cells);
    return 32'(addr) < 32'(num_cells);
  endfunction

endpackage

// File: rtl/text_clear_engine.sv
// Clear-screen engine: walks every valid cell once, writing the clear character
// with the live attribute input whenever the arbiter grants it a slot.
module text_clear_engine
  import text_ram_pkg::*;
#(
  parameter int         NUM_CELLS  = DEF_NUM_CELLS,
  parameter logic [7:0] CLEAR_CHAR = DEF_CLEAR_CHAR
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        start,
  input  logic [7:0]  attr,
  input  logic        gnt,
  output logic        req,
  output logic [11:0] addr,
  output logic [15:0] wdata,
  output logic        busy
);

  localparam logic [11:0] LAST_CELL = 12'(NUM_CELLS - 1);

  logic [11:0] count;

  // A start pulse always wins, so a restart mid-clear goes straight back to cell 0.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      count <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      count <= '0;
      busy  <= 1'b1;
    end else if (busy && gnt) begin
      if (count == LAST_CELL) begin
        count <= '0;
        busy  <= 1'b0;
      end else begin
        count <= count + 12'd1;
      end
    end
  end

  assign req   = busy;
  assign addr  = count;
  assign wdata = {attr, CLEAR_CHAR};

endmodule

// File: rtl/text_ram_arbiter.sv
// Single-port text RAM arbiter: video fetch beats Wishbone beats clear engine,
// one RAM access per cycle, RAM controls decoded combinationally from the grant.
module text_ram_arbiter
  import text_ram_pkg::*;
#(
  parameter int         NUM_CELLS  = DEF_NUM_CELLS,
  parameter logic [7:0] CLEAR_CHAR = DEF_CLEAR_CHAR
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_vid_req,
  input  logic [11:0] I_vid_addr,
  output logic [7:0]  O_vid_char,
  output logic [7:0]  O_vid_attr,
  output logic        O_vid_valid,
  input  logic        I_wb_cyc,
  input  logic        I_wb_stb,
  input  logic        I_wb_we,
  input  logic [11:0] I_wb_adr,
  input  logic [1:0]  I_wb_sel,
  input  logic [15:0] I_wb_dat,
  output logic [15:0] O_wb_dat,
  output logic        O_wb_ack,
  input  logic        I_clr_start,
  input  logic [7:0]  I_clr_attr,
  output logic        O_clr_busy,
  output logic        O_ram_en,
  output logic [1:0]  O_ram_we,
  output logic [11:0] O_ram_addr,
  output logic [15:0] O_ram_wdata,
  input  logic [15:0] I_ram_rdata
);

  gnt_e        gnt;
  wb_state_e   wb_state;
  wb_state_e   wb_next;
  logic        vid_req;
  logic        vid_oor;
  logic        wb_req;
  logic        wb_oor;
  logic        clr_req;
  logic [11:0] clr_addr;
  logic [15:0] clr_wdata;
  logic        vid_pend;
  logic        vid_pend_oor;
  logic        wb_rd_oor;

  // The RAM controls are combinational, so the raw request is masked while in reset.
  assign vid_req = I_vid_req & I_rst_n;
  assign vid_oor = !in_range(I_vid_addr, NUM_CELLS);
  assign wb_oor  = !in_range(I_wb_adr, NUM_CELLS);
  assign wb_req  = (wb_state == WB_WAIT_GNT) && I_wb_cyc;

  text_clear_engine #(
    .NUM_CELLS (NUM_CELLS),
    .CLEAR_CHAR(CLEAR_CHAR)
  ) u_clear (
    .I_clk  (I_clk),
    .I_rst_n(I_rst_n),
    .start  (I_clr_start),
    .attr   (I_clr_attr),
    .gnt    (gnt == GNT_CLR),
    .req    (clr_req),
    .addr   (clr_addr),
    .wdata  (clr_wdata),
    .busy   (O_clr_busy)
  );

  always_comb begin
    gnt = GNT_NONE;
    if (vid_req) begin
      gnt = GNT_VID;
    end else if (wb_req) begin
      gnt = GNT_WB;
    end else if (clr_req) begin
      gnt = GNT_CLR;
    end
  end

  // Out-of-range video and Wishbone accesses keep their slot but never touch the RAM.
  always_comb begin
    O_ram_en    = 1'b0;
    O_ram_we    = 2'b00;
    O_ram_addr  = '0;
    O_ram_wdata = '0;
    case (gnt)
      GNT_VID: begin
        O_ram_en   = !vid_oor;
        O_ram_addr = I_vid_addr;
      end
      GNT_WB: begin
        O_ram_en    = !wb_oor;
        O_ram_we    = (I_wb_we && !wb_oor) ? I_wb_sel : 2'b00;
        O_ram_addr  = I_wb_adr;
        O_ram_wdata = I_wb_dat;
      end
      GNT_CLR: begin
        O_ram_en    = 1'b1;
        O_ram_we    = 2'b11;
        O_ram_addr  = clr_addr;
        O_ram_wdata = clr_wdata;
      end
      default: begin
        O_ram_en = 1'b0;
      end
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      wb_state <= WB_IDLE;
    end else begin
      wb_state <= wb_next;
    end
  end

  always_comb begin
    wb_next = wb_state;
    case (wb_state)
      WB_IDLE: begin
        if (I_wb_cyc && I_wb_stb) begin
          wb_next = WB_WAIT_GNT;
        end
      end
      WB_WAIT_GNT: begin
        if (!I_wb_cyc) begin
          wb_next = WB_IDLE;
        end else if (gnt == GNT_WB) begin
          wb_next = I_wb_we ? WB_ACK : WB_RD_DATA;
        end
      end
      WB_RD_DATA: wb_next = WB_ACK;
      WB_ACK:     wb_next = WB_IDLE;
      default:    wb_next = WB_IDLE;
    endcase
  end

  // Video return is a fixed two-stage pipe: RAM latency, then the output register.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      vid_pend     <= 1'b0;
      vid_pend_oor <= 1'b0;
      O_vid_valid  <= 1'b0;
      O_vid_char   <= '0;
      O_vid_attr   <= '0;
      O_wb_ack     <= 1'b0;
      O_wb_dat     <= '0;
      wb_rd_oor    <= 1'b0;
    end else begin
      vid_pend     <= vid_req;
      vid_pend_oor <= vid_oor;
      O_vid_valid  <= vid_pend;
      if (vid_pend) begin
        O_vid_char <= vid_pend_oor ? 8'h00 : I_ram_rdata[CHAR_LANE*8 +: 8];
        O_vid_attr <= vid_pend_oor ? 8'h00 : I_ram_rdata[ATTR_LANE*8 +: 8];
      end
      O_wb_ack <= (wb_next == WB_ACK);
      if (gnt == GNT_WB) begin
        wb_rd_oor <= wb_oor;
      end
      if (wb_state == WB_RD_DATA) begin
        O_wb_dat <= wb_rd_oor ? 16'h0000 : I_ram_rdata;
      end
    end
  end

endmodule
